mux_n_pipe: RTL

Parametrised N-input, WIDTH-bit selector with a registered output and a two-entry skid buffer under valid/ready flow control. It is the pipelined successor of the 3-input 16-bit datapath mux. It sits between operand or forwarding sources and a downstream stage that can stall. Out-of-range selects are defined and reported: they produce the held last-good value (or zero), never an implicit latch.

---
 rtl/mux_n_pipe_pkg.sv | 14 +
 rtl/mux_n_comb.sv | 30 +++
 rtl/mux_n_pipe.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mux_n_pipe_pkg.sv
// Shared constants for the pipelined N-way selector.
//   BUS_W    : default datapath width
//   DEF_N_IN : default number of selectable inputs
//   sel_w_f  : select width for a given input count, never less than 1 bit
package mux_n_pipe_pkg;

  localparam int unsigned BUS_W    = 16;
  localparam int unsigned DEF_N_IN = 3;

  function automatic int unsigned sel_w_f(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Pure combinational N-way slice selector.
//   in_data : N_IN words, word k at bits [k*WIDTH +: WIDTH]
//   sel     : word index
//   data    : selected word, zero when sel is out of range
//   bad     : high when sel >= N_IN
module mux_n_comb
  import mux_n_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH = BUS_W,
  parameter  int unsigned N_IN  = DEF_N_IN,
  localparam int unsigned SEL_W = sel_w_f(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data,
  output logic                  bad
);

  always_comb begin
    data = '0;
    bad  = 1'b1;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data = in_data[k*WIDTH +: WIDTH];
        bad  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input WIDTH-bit selector with a registered output and a two-entry skid
// buffer under valid/ready flow control.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : N_IN flattened words, word k at [k*WIDTH +: WIDTH]
//   sel        : word index, sampled on accept
//   in_valid   : upstream word present
//   in_ready   : registered; low only while main and skid are both full
//   out_data   : selected word (main register)
//   out_valid  : out_data valid
//   out_ready  : downstream accepts
//   sel_err    : sticky, set when an out-of-range select is accepted
//   err_clr    : clears sel_err (a simultaneous set wins)
// An out-of-range select yields the last in-range value accepted, or zero
// when BAD_SEL_ZERO is set.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH        = BUS_W,
  parameter  int unsigned N_IN         = DEF_N_IN,
  parameter  bit          BAD_SEL_ZERO = 1'b0,
  localparam int unsigned SEL_W        = sel_w_f(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0]   last_good_q, last_good_d;
  logic               sel_err_q, sel_err_d;
  logic               in_ready_q, in_ready_d;

  logic [WIDTH-1:0]   mux_data;
  logic               mux_bad;
  logic [WIDTH-1:0]   sel_val;
  logic               accept;
  logic               xfer;

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_mux (
    .in_data (in_data),
    .sel     (sel),
    .data    (mux_data),
    .bad     (mux_bad)
  );

  always_comb begin
    if (!mux_bad) begin
      sel_val = mux_data;
    end else if (BAD_SEL_ZERO) begin
      sel_val = '0;
    end else begin
      sel_val = last_good_q;
    end
  end

  assign accept = in_valid & in_ready_q;
  assign xfer   = out_valid_q & out_ready;

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    last_good_d  = last_good_q;
    sel_err_d    = sel_err_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_data_d  = sel_val;
          out_valid_d = 1'b1;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          out_data_d = sel_val;
        end else if (accept) begin
          skid_data_d  = sel_val;
          skid_valid_d = 1'b1;
          state_d      = ST_FULL;
        end else if (xfer) begin
          out_valid_d = 1'b0;
          state_d     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain into main can happen.
        if (xfer) begin
          out_data_d   = skid_data_q;
          skid_valid_d = 1'b0;
          state_d      = ST_ONE;
        end
      end
      default: begin
        state_d      = ST_EMPTY;
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase

    if (accept && !mux_bad) begin
      last_good_d = mux_data;
    end

    if (accept && mux_bad) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end

    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      last_good_q  <= '0;
      sel_err_q    <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      last_good_q  <= last_good_d;
      sel_err_q    <= sel_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule
